// File: rtl/fetch_ctrl_rv32i_pkg.sv
// Shared definitions for the RV32I fetch controller: FSM encoding, datapath width,
// PC increment and an alignment helper.
package fetch_ctrl_rv32i_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_INC = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ctrl_rv32i_pc_next_sel.sv
// Next-PC selection: aligned redirect target, sequential PC+4 (wraps mod 2^32), or hold.
// A misaligned redirect holds the PC and raises misaligned_o for the FSM.
module pc_next_sel_rv32i
  import fetch_ctrl_rv32i_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] target_i,
  input  logic            advance_i,
  output logic [XLEN-1:0] pc_next_o,
  output logic            misaligned_o
);

  always_comb begin
    misaligned_o = redirect_i && !is_word_aligned(target_i);
    pc_next_o    = pc_i;
    if (redirect_i) begin
      if (is_word_aligned(target_i)) begin
        pc_next_o = target_i;
      end
    end else if (advance_i) begin
      pc_next_o = pc_i + INSTR_INC;
    end
  end

endmodule

// File: rtl/fetch_ctrl_rv32i.sv
// RV32I instruction fetch controller: IDLE/RUN/FAULT FSM, PC register and IF output registers.
// Optional fetch counter enabled by macro FETCH_PERF_CNT_EN.
module fetch_ctrl_rv32i
  import fetch_ctrl_rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            fetch_fault,
  output logic [1:0]      dbg_state_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] fetch_count
`endif
);

  // Handshake: a fetch is accepted when imem_req && imem_ready in the same cycle,
  // unless a redirect is also present, in which case the returned word is dropped.
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] ipc_q;
  logic            fault_q;

  logic run;
  logic hold;
  logic redirect_en;
  logic accept;
  logic misaligned;

  assign run         = (state_q == ST_RUN);
  assign hold        = valid_q && id_stall;
  assign redirect_en = run && redirect_valid;
  assign accept      = imem_req && imem_ready && !redirect_valid;

  pc_next_sel_rv32i u_pc_next_sel (
    .pc_i         (pc_q),
    .redirect_i   (redirect_en),
    .target_i     (redirect_target),
    .advance_i    (accept),
    .pc_next_o    (pc_d),
    .misaligned_o (misaligned)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_RUN;
      ST_RUN:   if (misaligned) state_d = ST_FAULT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    if (state_q == ST_RUN) begin
      imem_req = !hold;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= {RESET_PC[31:2], 2'b00};
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (redirect_en) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
        instr_q <= imem_rdata;
        ipc_q   <= pc_q;
      end else if (!hold) begin
        valid_q <= 1'b0;
      end
      if (misaligned) begin
        fault_q <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign fetch_count = cnt_q;
`endif

  assign imem_addr   = pc_q;
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = ipc_q;
  assign fetch_fault = fault_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_ctrl_rv32i.sv
// Directed testbench for fetch_ctrl_rv32i with RESET_PC = 0x1000.
module tb_fetch_ctrl_rv32i;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        fetch_fault;
  logic [1:0]  dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  fetch_ctrl_rv32i #(.RESET_PC(32'h0000_1000)) dut (
    .clock           (clock),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .id_stall        (id_stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fetch_fault     (fetch_fault),
    .dbg_state_o     (dbg_state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count     (fetch_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0;
    id_stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    tick(); tick();
    chk("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    chk("rst_addr", imem_addr, 32'h0000_1000);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_ifpc", if_pc, 32'h0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_count", fetch_count, 32'd0);
`endif

    // Sequential fetch from RESET_PC with ready tied high
    reset = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0000_00A0;
    tick();
    chk("run_state", {30'd0, dbg_state}, {30'd0, S_RUN});
    chk("seq_addr0", imem_addr, 32'h0000_1000);
    chk("seq_req0", {31'd0, imem_req}, 32'd1);
    chk("seq_valid0", {31'd0, if_valid}, 32'd0);
    tick();
    chk("seq_valid1", {31'd0, if_valid}, 32'd1);
    chk("seq_instr1", if_instr, 32'h0000_00A0);
    chk("seq_ifpc1", if_pc, 32'h0000_1000);
    chk("seq_addr1", imem_addr, 32'h0000_1004);
    imem_rdata = 32'h0000_00A1;
    tick();
    chk("seq_instr2", if_instr, 32'h0000_00A1);
    chk("seq_ifpc2", if_pc, 32'h0000_1004);
    chk("seq_addr2", imem_addr, 32'h0000_1008);

    // Decode stall for three cycles holds everything
    imem_rdata = 32'h0050_0093;
    tick();
    chk("stl_instr", if_instr, 32'h0050_0093);
    chk("stl_addr", imem_addr, 32'h0000_100C);
    id_stall = 1'b1; imem_rdata = 32'h1111_1111;
    #1;
    chk("stl_req_comb", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stl_hold_valid", {31'd0, if_valid}, 32'd1);
      chk("stl_hold_instr", if_instr, 32'h0050_0093);
      chk("stl_hold_ifpc", if_pc, 32'h0000_1008);
      chk("stl_hold_addr", imem_addr, 32'h0000_100C);
      chk("stl_hold_req", {31'd0, imem_req}, 32'd0);
    end
    id_stall = 1'b0; imem_rdata = 32'h0000_00B0;
    #1;
    chk("stl_release_req", {31'd0, imem_req}, 32'd1);
    tick();
    chk("resume_instr", if_instr, 32'h0000_00B0);
    chk("resume_ifpc", if_pc, 32'h0000_100C);
    chk("resume_addr", imem_addr, 32'h0000_1010);

    // Redirect with same-cycle ready: word discarded, no increment
    redirect_valid = 1'b1; redirect_target = 32'h0000_2000; imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("rdr_valid", {31'd0, if_valid}, 32'd0);
    chk("rdr_addr", imem_addr, 32'h0000_2000);
    redirect_valid = 1'b0; imem_rdata = 32'h0000_00C0;
    tick();
    chk("rdr_next_instr", if_instr, 32'h0000_00C0);
    chk("rdr_next_ifpc", if_pc, 32'h0000_2000);
    chk("rdr_next_addr", imem_addr, 32'h0000_2004);

    // No accepted fetch and no stall: if_valid drops
    imem_ready = 1'b0;
    tick();
    chk("drain_valid", {31'd0, if_valid}, 32'd0);
    chk("drain_addr", imem_addr, 32'h0000_2004);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    chk("wrap_addr_pre", imem_addr, 32'hFFFF_FFFC);
    redirect_valid = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0000_00E0;
    tick();
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    chk("wrap_ifpc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_fault", {31'd0, fetch_fault}, 32'd0);

    // Reset mid-fetch with ready asserted during reset
    reset = 1'b1; imem_rdata = 32'h0000_0BAD;
    tick();
    chk("midrst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    chk("midrst_valid", {31'd0, if_valid}, 32'd0);
    chk("midrst_addr", imem_addr, 32'h0000_1000);
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("midrst_count", fetch_count, 32'd0);
`endif
    reset = 1'b0;
    tick();
    chk("postrst_valid", {31'd0, if_valid}, 32'd0);
    chk("postrst_addr", imem_addr, 32'h0000_1000);
    imem_rdata = 32'h0000_00F0;
    tick();
    chk("restart_instr", if_instr, 32'h0000_00F0);
    chk("restart_ifpc", if_pc, 32'h0000_1000);
`ifdef FETCH_PERF_CNT_EN
    chk("restart_count", fetch_count, 32'd1);
`endif

    // Misaligned redirect is sticky until reset
    redirect_valid = 1'b1; redirect_target = 32'h0000_2002;
    tick();
    chk("flt_flag", {31'd0, fetch_fault}, 32'd1);
    chk("flt_state", {30'd0, dbg_state}, {30'd0, S_FAULT});
    chk("flt_req", {31'd0, imem_req}, 32'd0);
    chk("flt_valid", {31'd0, if_valid}, 32'd0);
    chk("flt_addr", imem_addr, 32'h0000_1004);
    redirect_target = 32'h0000_3000;
    tick();
    chk("flt_ignore_addr", imem_addr, 32'h0000_1004);
    chk("flt_ignore_flag", {31'd0, fetch_fault}, 32'd1);
    redirect_valid = 1'b0;
    tick();
    chk("flt_persist_req", {31'd0, imem_req}, 32'd0);
    chk("flt_persist_valid", {31'd0, if_valid}, 32'd0);
    reset = 1'b1;
    tick();
    chk("flt_clear_flag", {31'd0, fetch_fault}, 32'd0);
    chk("flt_clear_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    chk("flt_clear_addr", imem_addr, 32'h0000_1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl_rv32i.md
FETCH_CTRL_RV32I -- requirements
Module: fetch_ctrl_rv32i

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-004 imem_req  output  1  SHALL signal an instruction-memory fetch request.
REQ-005 imem_addr  output  32  SHALL carry the fetch address, which equals the current PC.
REQ-006 imem_ready  input  1  SHALL mean imem_rdata is valid for the requested address in this cycle.
REQ-007 imem_rdata  input  32  SHALL be the fetched instruction word.
REQ-008 if_valid  output  1  SHALL mean if_instr/if_pc hold a valid fetched instruction.
REQ-009 if_instr  output  32  SHALL be the fetched instruction.
REQ-010 if_pc  output  32  SHALL be the address of if_instr.
REQ-011 id_stall  input  1  SHALL mean the decode stage cannot accept the held instruction.
REQ-012 redirect_valid  input  1  SHALL request a PC change (branch/jump).
REQ-013 redirect_target  input  32  SHALL be the new PC on redirect.
REQ-014 fetch_fault  output  1  SHALL flag a misaligned redirect target (sticky).

Function
REQ-015 FSM states SHALL be IDLE, RUN, FAULT; IDLE->RUN unconditionally the cycle after reset deasserts.
REQ-016 In RUN, imem_req SHALL be 1 except when if_valid=1 and id_stall=1; IDLE and FAULT SHALL drive imem_req=0.
REQ-017 On imem_req=1 and imem_ready=1, the next cycle SHALL show if_valid=1, if_instr=imem_rdata, if_pc=old PC, and PC=old PC+4.
REQ-018 PC+4 SHALL be modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
REQ-019 While if_valid=1 and id_stall=1, if_valid/if_instr/if_pc SHALL hold unchanged, and the PC SHALL not advance.
REQ-020 With if_valid=1, id_stall=0 and no accepted fetch, if_valid SHALL clear next cycle.
REQ-021 redirect_valid=1 in RUN SHALL have priority: next cycle PC=redirect_target, if_valid=0; a same-cycle imem_ready SHALL be discarded and the PC SHALL not increment.
REQ-022 A redirect with redirect_target[1:0]!=2'b00 SHALL move to FAULT, set fetch_fault=1, clear if_valid, and leave the PC unchanged.
REQ-023 FAULT SHALL be left only by reset; redirect_valid and imem_ready SHALL be ignored there.
REQ-024 PC bits [1:0] SHALL always be 2'b00.

Reset
REQ-025 reset SHALL override all inputs: next cycle state=IDLE, PC=RESET_PC, imem_req=0, if_valid=0, if_instr=0, if_pc=0, fetch_fault=0.
REQ-026 Reset during an outstanding fetch SHALL abandon that fetch; a subsequent imem_ready SHALL be ignored until RUN re-issues a request.

Configuration
REQ-027 With macro FETCH_PERF_CNT_EN defined, the block SHALL add output fetch_count (32 bits), reset to 0, incrementing (wrapping) on every accepted fetch per REQ-017.
REQ-028 Without FETCH_PERF_CNT_EN, no fetch_count port or counter logic SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (IDLE/RUN/FAULT), the 32-bit XLEN constant, and the instruction-increment constant 4.
REQ-030 The next-PC selection (redirect target vs PC+4 vs hold) SHALL be a sub-module named pc_next_sel_rv32i; the FSM, PC register and output registers stay in fetch_ctrl_rv32i.

Verification
REQ-031 Reset with RESET_PC=32'h0000_1000, imem_ready tied 1 -> imem_addr sequence 0x1000, 0x1004, 0x1008; if_pc lags one cycle.
REQ-032 id_stall=1 for 3 cycles while if_valid=1 (if_instr=0x00500093) -> outputs held, imem_req=0, PC frozen; fetching resumes the cycle after stall drops.
REQ-033 redirect_valid=1, target=0x0000_2000, with imem_ready=1 in the same cycle -> next cycle if_valid=0 and imem_addr=0x2000; the data fetched in the redirect cycle is never presented.
REQ-034 Redirect target=0x0000_2002 -> fetch_fault=1, imem_req=0 persistently; a later valid redirect is ignored until reset.
REQ-035 PC=0xFFFF_FFFC with a fetch accepted -> next imem_addr=0x0000_0000, no fault.
REQ-036 reset asserted one cycle mid-fetch, imem_ready asserted during reset -> no if_valid; fetch restarts at RESET_PC; fetch_count (if enabled) is 0.
